// File: rtl/subservient_wb_pkg.sv
// subservient_wb_pkg: shared FSM type and constants for the subservient Wishbone bridge.
package subservient_wb_pkg;

    // Bridge transaction states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLocal = 2'd1,
        StFwd   = 2'd2,
        StResp  = 2'd3
    } wb_state_e;

    // Offset bit that splits the window into forwarded (0) and local register (1) halves
    localparam int unsigned LOCAL_SEL = 19;

    localparam logic [31:0] CTRL_OFS   = 32'h0008_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0008_0004;

    // CTRL = {core_rst, debug_mode}; core held in reset with debug bus enabled
    localparam logic [1:0] CTRL_RST = 2'b11;

    // Read data returned for a forwarded access that timed out
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Offset of an address within the user-project window
    function automatic logic [31:0] wb_offset(input logic [31:0] adr, input logic [31:0] mask);
        return adr & ~mask;
    endfunction

endpackage

// File: rtl/subservient_wb_timeout.sv
// subservient_wb_timeout: cycle counter bounding a forwarded access. Counts while enabled,
// restarts from 0 on clear, flags expiry on the cycle the count reaches TIMEOUT-1.
module subservient_wb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while enabled and short of the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clear_i && (cnt_q == LastCnt);

endmodule

// File: rtl/subservient_wb_bridge.sv
// subservient_wb_bridge: decodes the Caravel management Wishbone bus for the user-project
// window, serves a local CTRL/STATUS bank and forwards the lower half of the window to the
// subservient debug bus.
// Build option: define SUBSERVIENT_WB_TIMEOUT_EN to bound forwarded accesses to TIMEOUT
// cycles; without it a forwarded access waits for the downstream ack indefinitely.
module subservient_wb_bridge
    import subservient_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter logic [31:0] WIN_MASK = 32'hFFF0_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wbs_cyc,
    input  logic        i_wbs_stb,
    input  logic        i_wbs_we,
    input  logic [3:0]  i_wbs_sel,
    input  logic [31:0] i_wbs_adr,
    input  logic [31:0] i_wbs_dat,
    output logic        o_wbs_ack,
    output logic [31:0] o_wbs_dat,
    output logic [31:0] o_wb_dbg_adr,
    output logic [31:0] o_wb_dbg_dat,
    output logic [3:0]  o_wb_dbg_sel,
    output logic        o_wb_dbg_we,
    output logic        o_wb_dbg_stb,
    input  logic [31:0] i_wb_dbg_rdt,
    input  logic        i_wb_dbg_ack,
    output logic        o_debug_mode,
    output logic        o_core_rst,
    input  logic        i_gpio
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("subservient_wb_bridge: TIMEOUT must be in 1..65535");
    end

    wb_state_e   state_q, state_d;

    // Latched request
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [31:0] rdata_q;
    logic [1:0]  ctrl_q;
    logic        timeout_q;
    logic        fwd_err_q;
    // High in the idle cycle right after an ack, while the master is still dropping stb
    logic        ack_gap_q;

    logic        hit;
    logic        hit_local;
    logic [31:0] req_ofs;
    logic [31:0] local_rdata;
    logic        ctrl_wr;
    logic        status_wr;
    logic        fwd_expire;

    assign hit = i_wbs_cyc && i_wbs_stb && ((i_wbs_adr & WIN_MASK) == BASE_ADR) && !ack_gap_q;
    assign hit_local = i_wbs_adr[LOCAL_SEL] & ~WIN_MASK[LOCAL_SEL];

    assign req_ofs   = wb_offset(adr_q, WIN_MASK);
    assign ctrl_wr   = (state_q == StLocal) && we_q && sel_q[0] && (req_ofs == CTRL_OFS);
    assign status_wr = (state_q == StLocal) && we_q && sel_q[0] && (req_ofs == STATUS_OFS);

`ifdef SUBSERVIENT_WB_TIMEOUT_EN
    subservient_wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .clear_i (state_q != StFwd),
        .en_i    (state_q == StFwd),
        .expire_o(fwd_expire)
    );
`else
    assign fwd_expire = 1'b0;
`endif

    // Local register read mux; unmapped local offsets read as zero
    always_comb begin
        local_rdata = '0;
        if (req_ofs == CTRL_OFS) begin
            local_rdata = {30'b0, ctrl_q};
        end else if (req_ofs == STATUS_OFS) begin
            local_rdata = {29'b0, i_gpio, fwd_err_q, timeout_q};
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    if (hit_local) begin
                        state_d = StLocal;
                    end else if (ctrl_q[0]) begin
                        state_d = StFwd;
                    end else begin
                        // Debug bus disabled: answer at once with an error flag
                        state_d = StResp;
                    end
                end
            end
            StLocal: state_d = StResp;
            StFwd: begin
                // Ack takes priority over a coincident expiry
                if (i_wb_dbg_ack || fwd_expire) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_wbs_ack    = 1'b0;
        o_wbs_dat    = '0;
        o_wb_dbg_stb = 1'b0;
        unique case (state_q)
            StFwd: o_wb_dbg_stb = 1'b1;
            StResp: begin
                o_wbs_ack = 1'b1;
                o_wbs_dat = rdata_q;
            end
            default: ;
        endcase
    end

    // Request latch, response data, CTRL and sticky STATUS bits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= CTRL_RST;
            timeout_q <= 1'b0;
            fwd_err_q <= 1'b0;
            ack_gap_q <= 1'b0;
        end else begin
            ack_gap_q <= (state_q == StResp);

            if (state_q == StIdle && hit) begin
                adr_q <= i_wbs_adr;
                dat_q <= i_wbs_dat;
                sel_q <= i_wbs_sel;
                we_q  <= i_wbs_we;
                if (!hit_local && !ctrl_q[0]) begin
                    rdata_q   <= '0;
                    fwd_err_q <= 1'b1;
                end
            end

            if (state_q == StLocal) begin
                rdata_q <= local_rdata;
            end
            if (ctrl_wr) begin
                ctrl_q <= dat_q[1:0];
            end
            if (status_wr) begin
                if (dat_q[0]) begin
                    timeout_q <= 1'b0;
                end
                if (dat_q[1]) begin
                    fwd_err_q <= 1'b0;
                end
            end

            if (state_q == StFwd) begin
                if (i_wb_dbg_ack) begin
                    rdata_q <= i_wb_dbg_rdt;
                end else if (fwd_expire) begin
                    rdata_q   <= ERR_DATA;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign o_wb_dbg_adr = req_ofs;
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = sel_q;
    assign o_wb_dbg_we  = we_q;
    assign o_debug_mode = ctrl_q[0];
    assign o_core_rst   = ctrl_q[1];

endmodule

// File: tb/tb_subservient_wb_bridge.sv
// tb_subservient_wb_bridge: directed scenarios plus randomized traffic against a
// transaction-level model of the bridge.
module tb_subservient_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFF0_0000;
    localparam int TMO = 16;
`ifdef SUBSERVIENT_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]  wbs_sel;
    logic [31:0] wbs_adr, wbs_dat;
    logic        o_wbs_ack;
    logic [31:0] o_wbs_dat;
    logic [31:0] o_wb_dbg_adr, o_wb_dbg_dat;
    logic [3:0]  o_wb_dbg_sel;
    logic        o_wb_dbg_we, o_wb_dbg_stb;
    logic [31:0] dbg_rdt;
    logic        dbg_ack;
    logic        o_debug_mode, o_core_rst;
    logic        gpio;

    int checks = 0;
    int errors = 0;

    // Model state: CTRL bits and STATUS sticky flags
    bit m_dbg, m_crst, m_to, m_err;

    typedef struct {
        bit          ack;
        int          lat;
        logic [31:0] data;
        int          stbn;
    } exp_t;

    always #5 clk = ~clk;

    subservient_wb_bridge #(
        .BASE_ADR(BASE),
        .WIN_MASK(MASK),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wbs_cyc   (wbs_cyc),
        .i_wbs_stb   (wbs_stb),
        .i_wbs_we    (wbs_we),
        .i_wbs_sel   (wbs_sel),
        .i_wbs_adr   (wbs_adr),
        .i_wbs_dat   (wbs_dat),
        .o_wbs_ack   (o_wbs_ack),
        .o_wbs_dat   (o_wbs_dat),
        .o_wb_dbg_adr(o_wb_dbg_adr),
        .o_wb_dbg_dat(o_wb_dbg_dat),
        .o_wb_dbg_sel(o_wb_dbg_sel),
        .o_wb_dbg_we (o_wb_dbg_we),
        .o_wb_dbg_stb(o_wb_dbg_stb),
        .i_wb_dbg_rdt(dbg_rdt),
        .i_wb_dbg_ack(dbg_ack),
        .o_debug_mode(o_debug_mode),
        .o_core_rst  (o_core_rst),
        .i_gpio      (gpio)
    );

    // Expected outcome of one access; updates the model registers as a side effect
    function automatic exp_t model_xfer(input logic [31:0] adr, input logic we,
                                        input logic [31:0] dat, input logic [3:0] sel,
                                        input int dly, input logic [31:0] rdt, input bit g);
        exp_t e;
        logic [31:0] ofs;
        e = '{ack: 1'b0, lat: 0, data: 32'h0, stbn: 0};
        if ((adr & MASK) != BASE) return e;
        ofs = adr - BASE;
        e.ack = 1'b1;
        if (ofs >= 32'h0008_0000) begin
            e.lat = 2;
            if (ofs == 32'h0008_0000) begin
                e.data = {30'b0, m_crst, m_dbg};
                if (we && sel[0]) begin
                    m_crst = dat[1];
                    m_dbg  = dat[0];
                end
            end else if (ofs == 32'h0008_0004) begin
                e.data = {29'b0, g, m_err, m_to};
                if (we && sel[0]) begin
                    if (dat[0]) m_to = 1'b0;
                    if (dat[1]) m_err = 1'b0;
                end
            end
        end else if (!m_dbg) begin
            e.lat = 1;
            m_err = 1'b1;
        end else if (TO_EN && (dly < 1 || dly > TMO)) begin
            e.lat  = TMO + 1;
            e.data = 32'hDEAD_BEEF;
            e.stbn = TMO;
            m_to   = 1'b1;
        end else begin
            e.lat  = dly + 1;
            e.data = rdt;
            e.stbn = dly;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 0; wbs_adr = 0; wbs_dat = 0;
        dbg_ack = 0; dbg_rdt = 0; gpio = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_dbg = 1; m_crst = 1; m_to = 0; m_err = 0;
    endtask

    // Master + downstream responder for one access. Downstream acks on its dly-th strobe
    // cycle (never if dly < 1) and drives junk acks while not strobed.
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int dly, input logic [31:0] rdt,
                        output bit acked, output int lat, output logic [31:0] rdata,
                        output int stbn, output bit pay_ok, output bit ack_held);
        acked = 0; lat = 0; rdata = '0; stbn = 0; pay_ok = 1; ack_held = 0;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = we; wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
        dbg_ack = 1'($urandom_range(0, 1));
        dbg_rdt = $urandom();
        for (int n = 1; n <= 60 && !acked; n++) begin
            @(posedge clk); #1;
            dbg_ack = 1'b0;
            dbg_rdt = $urandom();
            if (o_wbs_ack) begin
                acked = 1; lat = n; rdata = o_wbs_dat;
            end else if (o_wb_dbg_stb) begin
                stbn++;
                if (o_wb_dbg_adr !== (adr & ~MASK) || o_wb_dbg_dat !== dat ||
                    o_wb_dbg_sel !== sel || o_wb_dbg_we !== we) pay_ok = 0;
                if (stbn == dly) begin
                    dbg_ack = 1'b1;
                    dbg_rdt = rdt;
                end
            end else begin
                dbg_ack = 1'($urandom_range(0, 1));
            end
        end
        wbs_cyc = 0; wbs_stb = 0; dbg_ack = 0;
        @(posedge clk); #1;
        if (o_wbs_ack) ack_held = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_wbs_ack !== 1'b0) begin errors++;
            $display("FAIL reset_ack: got %b want 0", o_wbs_ack); end
        checks++; if (o_wbs_dat !== 32'h0) begin errors++;
            $display("FAIL reset_dat: got %h want 0", o_wbs_dat); end
        checks++; if (o_wb_dbg_stb !== 1'b0) begin errors++;
            $display("FAIL reset_stb: got %b want 0", o_wb_dbg_stb); end
        checks++;
        if ({o_wb_dbg_adr, o_wb_dbg_dat, o_wb_dbg_sel, o_wb_dbg_we} !== 69'h0) begin errors++;
            $display("FAIL reset_payload: got %h %h %h %b want 0", o_wb_dbg_adr, o_wb_dbg_dat,
                     o_wb_dbg_sel, o_wb_dbg_we); end
        checks++; if ({o_core_rst, o_debug_mode} !== 2'b11) begin errors++;
            $display("FAIL reset_ctrl: got %b want 11", {o_core_rst, o_debug_mode}); end
    endtask

    task automatic test_local_read();
        bit a, h, p; int l, s; logic [31:0] d;
        xfer(32'h3008_0000, 0, 32'h0, 4'hF, 0, 32'h0, a, l, d, s, p, h);
        checks++; if (a !== 1'b1 || l != 2) begin errors++;
            $display("FAIL ctrl_read_lat: got ack=%b lat=%0d want ack=1 lat=2", a, l); end
        checks++; if (d !== 32'h3) begin errors++;
            $display("FAIL ctrl_read_data: got %h want 00000003", d); end
        checks++; if (h !== 1'b0) begin errors++;
            $display("FAIL ctrl_read_single_ack: ack held, want one cycle"); end
    endtask

    task automatic test_fwd_write();
        bit a, h, p; int l, s; logic [31:0] d, r;
        r = $urandom();
        xfer(32'h3000_0010, 1, 32'h1234_5678, 4'hF, 3, r, a, l, d, s, p, h);
        checks++; if (a !== 1'b1 || l != 4 || s != 3) begin errors++;
            $display("FAIL fwd_write_timing: got ack=%b lat=%0d stb=%0d want 1 4 3", a, l, s); end
        checks++; if (p !== 1'b1) begin errors++;
            $display("FAIL fwd_write_payload: got bad payload want adr 10 dat 12345678 we 1"); end
        checks++; if (d !== r || h !== 1'b0) begin errors++;
            $display("FAIL fwd_write_resp: got %h held=%b want %h held=0", d, h, r); end
    endtask

    task automatic test_timeout();
        bit a, h, p; int l, s; logic [31:0] d, r;
        r = $urandom();
`ifdef SUBSERVIENT_WB_TIMEOUT_EN
        xfer(32'h3000_0020, 0, 32'h0, 4'hF, -1, r, a, l, d, s, p, h);
        checks++; if (a !== 1'b1 || l != TMO + 1 || s != TMO) begin errors++;
            $display("FAIL timeout_timing: got ack=%b lat=%0d stb=%0d want 1 %0d %0d",
                     a, l, s, TMO + 1, TMO); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL timeout_data: got %h want deadbeef", d); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, r, a, l, d, s, p, h);
        checks++; if (d !== 32'h1) begin errors++;
            $display("FAIL timeout_status: got %h want 00000001", d); end
        xfer(32'h3008_0004, 1, 32'h1, 4'h1, 0, r, a, l, d, s, p, h);
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, r, a, l, d, s, p, h);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL timeout_w1c: got %h want 00000000", d); end
        xfer(32'h3000_0024, 0, 32'h0, 4'hF, TMO, r, a, l, d, s, p, h);
        checks++; if (l != TMO + 1 || d !== r) begin errors++;
            $display("FAIL ack_at_expiry: got lat=%0d %h want %0d %h", l, d, TMO + 1, r); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, r, a, l, d, s, p, h);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL ack_at_expiry_status: got %h want 00000000", d); end
`else
        xfer(32'h3000_0020, 0, 32'h0, 4'hF, 40, r, a, l, d, s, p, h);
        checks++; if (a !== 1'b1 || l != 41 || s != 40 || d !== r) begin errors++;
            $display("FAIL long_wait: got lat=%0d stb=%0d %h want 41 40 %h", l, s, d, r); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, r, a, l, d, s, p, h);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL long_wait_status: got %h want 00000000", d); end
`endif
    endtask

    task automatic test_fwd_disabled();
        bit a, h, p; int l, s; logic [31:0] d;
        xfer(32'h3008_0000, 1, 32'h0, 4'h1, 0, 32'h0, a, l, d, s, p, h);
        checks++; if ({o_core_rst, o_debug_mode} !== 2'b00) begin errors++;
            $display("FAIL ctrl_write: got %b want 00", {o_core_rst, o_debug_mode}); end
        xfer(32'h3000_0040, 1, 32'hCAFE_0001, 4'hF, 1, 32'h5555_5555, a, l, d, s, p, h);
        checks++; if (a !== 1'b1 || l != 1 || s != 0 || d !== 32'h0) begin errors++;
            $display("FAIL fwd_disabled: got ack=%b lat=%0d stb=%0d %h want 1 1 0 0",
                     a, l, s, d); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, 32'h0, a, l, d, s, p, h);
        checks++; if (d !== 32'h2) begin errors++;
            $display("FAIL fwd_err_status: got %h want 00000002", d); end
    endtask

    task automatic test_miss();
        bit a, h, p; int l, s; logic [31:0] d;
        xfer(32'h2000_0000, 1, 32'h1, 4'hF, 1, 32'h0, a, l, d, s, p, h);
        checks++; if (a !== 1'b0 || s != 0) begin errors++;
            $display("FAIL miss_low: got ack=%b stb=%0d want 0 0", a, s); end
        xfer(32'h3010_0000, 0, 32'h0, 4'hF, 1, 32'h0, a, l, d, s, p, h);
        checks++; if (a !== 1'b0 || s != 0) begin errors++;
            $display("FAIL miss_above: got ack=%b stb=%0d want 0 0", a, s); end
    endtask

    // Master keeps stb up through the cycle after ack; that must not start a new access
    task automatic test_back_to_back();
        bit a, h, p; int l, s, extra; logic [31:0] d;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3008_0000; wbs_sel = 4'hF;
        a = 0; extra = 0;
        for (int n = 0; n < 10 && !a; n++) begin
            @(posedge clk); #1;
            a = o_wbs_ack;
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (o_wbs_ack) extra++;
        end
        wbs_cyc = 0; wbs_stb = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_wbs_ack) extra++;
        end
        checks++; if (a !== 1'b1 || extra != 0) begin errors++;
            $display("FAIL held_stb: got ack=%b extra_acks=%0d want 1 0", a, extra); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, 32'h0, a, l, d, s, p, h);
        checks++; if (l != 2 || d !== 32'h2) begin errors++;
            $display("FAIL next_access: got lat=%0d %h want 2 00000002", l, d); end
    endtask

    task automatic test_reset_mid_fwd();
        bit a, h, p; int l, s, acks; logic [31:0] d;
        xfer(32'h3008_0000, 1, 32'h1, 4'h1, 0, 32'h0, a, l, d, s, p, h);
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3000_0100; dbg_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_wb_dbg_stb !== 1'b1) begin errors++;
            $display("FAIL rst_fwd_pre: got stb=%b want 1", o_wb_dbg_stb); end
        rst = 1; wbs_cyc = 0; wbs_stb = 0;
        @(posedge clk); #1;
        checks++; if (o_wb_dbg_stb !== 1'b0 || o_wbs_ack !== 1'b0) begin errors++;
            $display("FAIL rst_fwd_drop: got stb=%b ack=%b want 0 0", o_wb_dbg_stb, o_wbs_ack); end
        rst = 0;
        acks = 0;
        repeat (5) begin
            dbg_ack = 1;
            @(posedge clk); #1;
            if (o_wbs_ack) acks++;
        end
        dbg_ack = 0;
        m_dbg = 1; m_crst = 1; m_to = 0; m_err = 0;
        checks++; if (acks != 0 || {o_core_rst, o_debug_mode} !== 2'b11) begin errors++;
            $display("FAIL rst_fwd_after: got acks=%0d ctrl=%b want 0 11", acks,
                     {o_core_rst, o_debug_mode}); end
        xfer(32'h3008_0000, 0, 32'h0, 4'hF, 0, 32'h0, a, l, d, s, p, h);
        checks++; if (d !== 32'h3) begin errors++;
            $display("FAIL rst_fwd_ctrl: got %h want 00000003", d); end
        xfer(32'h3008_0004, 0, 32'h0, 4'hF, 0, 32'h0, a, l, d, s, p, h);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL rst_fwd_status: got %h want 00000000", d); end
    endtask

    task automatic test_random();
        bit a, h, p; int l, s, dly, kind; logic [31:0] d, r, adr, dat; logic [3:0] sel;
        logic we;
        exp_t e;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 7);
            we   = 1'($urandom_range(0, 1));
            dat  = $urandom();
            sel  = 4'($urandom());
            r    = $urandom();
            dly  = $urandom_range(1, 20);
            gpio = 1'($urandom_range(0, 1));
            unique case (kind)
                0: begin adr = BASE + 32'h8_0000; we = 1; dat[0] = ($urandom_range(0, 3) != 0); end
                1: adr = BASE + 32'h8_0000;
                2, 3: adr = BASE + 32'h8_0004;
                4: begin
                    adr = BASE + (32'h8_0000 | ($urandom() & 32'h7_FFFF));
                    if (adr - BASE < 32'h8_0008) adr = adr + 32'h10;
                end
                5, 6: adr = BASE + ($urandom() & 32'h7_FFFF);
                default: begin
                    adr = $urandom();
                    if ((adr & MASK) == BASE) adr = adr ^ 32'h8000_0000;
                end
            endcase
            e = model_xfer(adr, we, dat, sel, dly, r, gpio);
            xfer(adr, we, dat, sel, dly, r, a, l, d, s, p, h);
            checks++; if (a !== e.ack || s != e.stbn) begin errors++;
                $display("FAIL rnd_ack[%0d] adr=%h: got ack=%b stb=%0d want %b %0d",
                         i, adr, a, s, e.ack, e.stbn); end
            if (e.ack) begin
                checks++; if (l != e.lat || d !== e.data) begin errors++;
                    $display("FAIL rnd_resp[%0d] adr=%h: got lat=%0d %h want %0d %h",
                             i, adr, l, d, e.lat, e.data); end
            end
            checks++; if (p !== 1'b1 || h !== 1'b0) begin errors++;
                $display("FAIL rnd_bus[%0d]: got payload_ok=%b ack_held=%b want 1 0", i, p, h); end
            checks++; if ({o_core_rst, o_debug_mode} !== {m_crst, m_dbg}) begin errors++;
                $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {o_core_rst, o_debug_mode},
                         {m_crst, m_dbg}); end
        end
    endtask

    initial begin
        test_reset();
        test_local_read();
        test_fwd_write();
        test_timeout();
        test_fwd_disabled();
        test_miss();
        test_back_to_back();
        test_reset_mid_fwd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
